// File: rtl/ann_pkg.sv
// Shared fixed-point constants and types for the neuron post-processing path.
// Data format is signed Q6.10 (1.0 = 1024); sigmoid constants describe the
// PLAN piecewise-linear approximation.
package ann_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;

  localparam logic [DATA_W-1:0] Q_ONE = 16'd1024;
  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

  localparam logic [DATA_W-1:0] SIG_BP_LO  = 16'd1024;
  localparam logic [DATA_W-1:0] SIG_BP_MID = 16'd2432;
  localparam logic [DATA_W-1:0] SIG_BP_HI  = 16'd5120;

  localparam logic [DATA_W-1:0] SIG_OFF_LO  = 16'd512;
  localparam logic [DATA_W-1:0] SIG_OFF_MID = 16'd640;
  localparam logic [DATA_W-1:0] SIG_OFF_HI  = 16'd864;

  // One pipeline stage worth of payload
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [DATA_W-1:0] data;
  } stage_t;

  // Clamp a 17-bit two's-complement sum back into the 16-bit range
  function automatic logic [DATA_W-1:0] sat17(input logic [DATA_W:0] s);
    logic [DATA_W-1:0] r;
    if (!s[DATA_W] && s[DATA_W-1]) r = Q_MAX;
    else if (s[DATA_W] && !s[DATA_W-1]) r = Q_MIN;
    else r = s[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/act_sigmoid_plan.sv
// Combinational PLAN sigmoid on signed Q6.10 data.
// Evaluates the curve on |x| and mirrors it around 0.5 for negative inputs,
// so the result always lies in [0, 1.0].
module act_sigmoid_plan
  import ann_pkg::*;
(
  input  logic [DATA_W-1:0] i_x,
  output logic [DATA_W-1:0] o_y
);

  logic [DATA_W-1:0] w_abs;
  logic [DATA_W-1:0] w_mag;

  // Magnitude (most negative value folds to max), segment select, mirror
  always_comb begin
    w_abs = i_x;
    if (i_x == Q_MIN) w_abs = Q_MAX;
    else if (i_x[DATA_W-1]) w_abs = -i_x;

    if (w_abs >= SIG_BP_HI) w_mag = Q_ONE;
    else if (w_abs >= SIG_BP_MID) w_mag = (w_abs >> 5) + SIG_OFF_HI;
    else if (w_abs >= SIG_BP_LO) w_mag = (w_abs >> 3) + SIG_OFF_MID;
    else w_mag = (w_abs >> 2) + SIG_OFF_LO;

    o_y = i_x[DATA_W-1] ? (Q_ONE - w_mag) : w_mag;
  end

endmodule

// File: rtl/neuron_act.sv
// Per-neuron bias + activation stage behind the systolic PE column chain.
// Two-stage stall-able pipeline: stage 1 adds the saturated bias selected by
// an internal neuron index, stage 2 applies the activation.
// Build option: define ACT_SIGMOID_EN to use the PLAN sigmoid; otherwise ReLU.
module neuron_act
  import ann_pkg::*;
#(
  parameter int N_NEURON = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        bias_wr_en,
  input  logic [$clog2(N_NEURON)-1:0] bias_wr_addr,
  input  logic [DATA_W-1:0]           bias_wr_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_last
);

  localparam int IDX_W = $clog2(N_NEURON);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURON - 1);

  logic [DATA_W-1:0] r_bias [N_NEURON];
  logic [IDX_W-1:0]  r_idx;
  stage_t            r_s1;

  logic              w_adv;
  logic [DATA_W-1:0] w_bias;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_act;

  // Whole pipeline moves together whenever the output slot is free or draining
  assign w_adv   = !m_valid || m_ready;
  assign s_ready = w_adv;

  assign w_bias = r_bias[r_idx];
  assign w_sum  = {s_data[DATA_W-1], s_data} + {w_bias[DATA_W-1], w_bias};

`ifdef ACT_SIGMOID_EN
  act_sigmoid_plan u_sigmoid (
    .i_x (r_s1.data),
    .o_y (w_act)
  );
`else
  // ReLU: negative values clamp to zero
  always_comb begin
    w_act = r_s1.data[DATA_W-1] ? '0 : r_s1.data;
  end
`endif

  // Bias register file; a same-cycle accept still sees the previous value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURON; k++) r_bias[k] <= '0;
    end else if (bias_wr_en) begin
      r_bias[bias_wr_addr] <= bias_wr_data;
    end
  end

  // Pipeline stages and neuron index; clr flushes valid bits and the index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_idx   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (clr) begin
      r_s1.valid <= 1'b0;
      m_valid    <= 1'b0;
      r_idx      <= '0;
    end else if (w_adv) begin
      r_s1.valid <= s_valid;
      r_s1.last  <= s_valid && (r_idx == IDX_LAST);
      r_s1.data  <= sat17(w_sum);
      m_valid    <= r_s1.valid;
      m_data     <= w_act;
      m_last     <= r_s1.valid && r_s1.last;
      if (s_valid) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_neuron_act.sv
// Self-checking bench for neuron_act with a scoreboard queue.
// Follows ACT_SIGMOID_EN the same way as the design to pick the reference
// activation.
module tb_neuron_act;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        bias_wr_en;
  logic [1:0]  bias_wr_addr;
  logic [15:0] bias_wr_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;

  int          checks   = 0;
  int          failures = 0;
  logic [16:0] sbQ [$];
  int          mBias [N];
  int          mIdx;
  logic [15:0] held;

  neuron_act #(.N_NEURON(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .bias_wr_en   (bias_wr_en),
    .bias_wr_addr (bias_wr_addr),
    .bias_wr_data (bias_wr_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int satModel(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int sigModel(input int x);
    int a;
    int y;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    if (a >= 5120) y = 1024;
    else if (a >= 2432) y = a / 32 + 864;
    else if (a >= 1024) y = a / 8 + 640;
    else y = a / 4 + 512;
    if (x < 0) y = 1024 - y;
    return y;
  endfunction

  function automatic logic [16:0] expectFor(input logic [15:0] d);
    int x;
    int y;
    x = satModel(int'($signed(d)) + mBias[mIdx]);
`ifdef ACT_SIGMOID_EN
    y = sigModel(x);
`else
    y = (x < 0) ? 0 : x;
`endif
    return {(mIdx == N - 1), 16'(y)};
  endfunction

  // One clock cycle: observe handshakes mid-cycle, update scoreboard, clock
  task automatic stepCycle();
    logic [16:0] e;
    #4;
    if (m_valid && m_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_out", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        e = sbQ.pop_front();
        checkOutput("m_data", 32'(m_data), 32'(e[15:0]));
        checkOutput("m_last", 32'(m_last), 32'(e[16]));
      end
    end
    if (clr) begin
      sbQ.delete();
      mIdx = 0;
    end else if (s_valid && s_ready) begin
      sbQ.push_back(expectFor(s_data));
      mIdx = (mIdx + 1) % N;
    end
    if (bias_wr_en) mBias[bias_wr_addr] = int'($signed(bias_wr_data));
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input int d, input logic rdy, input logic c);
    s_valid = v;
    s_data  = 16'(d);
    m_ready = rdy;
    clr     = c;
    stepCycle();
    clr = 1'b0;
  endtask

  task automatic writeBias(input int addr, input int val);
    bias_wr_en   = 1'b1;
    bias_wr_addr = 2'(addr);
    bias_wr_data = 16'(val);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    bias_wr_en = 1'b0;
  endtask

  task automatic setAllBias(input int b0, input int b1, input int b2, input int b3);
    writeBias(0, b0);
    writeBias(1, b1);
    writeBias(2, b2);
    writeBias(3, b3);
  endtask

  task automatic drainOutputs();
    for (int i = 0; i < 20 && sbQ.size() != 0; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("drain_empty", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    int vec [4];
    rst_n = 1'b0; clr = 1'b0; bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    for (int k = 0; k < N; k++) mBias[k] = 0;
    mIdx = 0;
    #12;
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_m_last", 32'(m_last), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic stream
    setAllBias(0, 1024, -512, 0);
    vec = '{0, 0, 0, 1024};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, vec[i], 1'b1, 1'b0);
    drainOutputs();

    // Saturation, both directions
    setAllBias(10000, 10000, 10000, 10000);
    applyStimulus(1'b1, 30000, 1'b1, 1'b0);
    applyStimulus(1'b1, 32767, 1'b1, 1'b0);
    setAllBias(-10000, -10000, -10000, -10000);
    applyStimulus(1'b1, -30000, 1'b1, 1'b0);
    applyStimulus(1'b1, -32768, 1'b1, 1'b0);
    drainOutputs();

    // Sigmoid symmetry / extremes
    setAllBias(0, 0, 0, 0);
    vec = '{-1024, 3000, -32768, 500};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, vec[i], 1'b1, 1'b0);
    drainOutputs();

    // Backpressure in the middle of a continuous stream
    setAllBias(100, -200, 300, 7000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1000 * i - 1500, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2222 + i, 1'b0, 1'b0);
      if (i == 0) held = m_data;
      else checkOutput("stall_data", 32'(m_data), 32'(held));
      checkOutput("stall_valid", 32'(m_valid), 32'd1);
      checkOutput("stall_sready", 32'(s_ready), 32'd0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 400 * i - 900, 1'b1, 1'b0);
    drainOutputs();

    // clr with two items in flight
    applyStimulus(1'b1, 111, 1'b0, 1'b0);
    applyStimulus(1'b1, 222, 1'b0, 1'b0);
    applyStimulus(1'b1, 333, 1'b0, 1'b1);
    checkOutput("clr_m_valid", 32'(m_valid), 32'd0);
    applyStimulus(1'b1, 50, 1'b1, 1'b0);
    applyStimulus(1'b1, -50, 1'b1, 1'b0);
    drainOutputs();

    // Asynchronous reset in the middle of a stream
    applyStimulus(1'b1, 5000, 1'b1, 1'b0);
    applyStimulus(1'b1, 6000, 1'b1, 1'b0);
    applyStimulus(1'b1, 7000, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("arst_m_data", 32'(m_data), 32'd0);
    checkOutput("arst_m_last", 32'(m_last), 32'd0);
    sbQ.delete();
    mIdx = 0;
    for (int k = 0; k < N; k++) mBias[k] = 0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 1'b1, 1'b0);
    drainOutputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
